exp_operand_fetch: RTL and testbench
====================================

# exp_operand_fetch

Operand-fetch stage for the exponent datapath: the read-side client of the 8-entry, 2-read/2-write exponent register file. It accepts exponent-op requests, drives both register-file read selects, and tracks in-flight destination registers with a scoreboard. It stalls on RAW/WAW hazards, bypasses same-cycle writebacks, and presents a registered operand pair to the exponent execution unit over a valid/ready handshake.

## Interface
- REGISTER_WIDTH, 9, exponent register width
- ADDR_WIDTH, 3, register index width (2**ADDR_WIDTH entries)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid && ready
- req_srcA, req_srcB  in  ADDR_WIDTH  source register indices
- req_dst  in  ADDR_WIDTH  destination index
- req_dst_en  in  1  op writes req_dst
- rf_readSelectA, rf_readSelectB  out  ADDR_WIDTH  register-file read selects
- rf_readResultA, rf_readResultB  in  REGISTER_WIDTH  combinational read data for the current selects
- wb_enA, wb_enB  in  1  register-file write strobes (snooped)
- wb_addrA, wb_addrB  in  ADDR_WIDTH  write indices
- wb_valueA, wb_valueB  in  REGISTER_WIDTH  write data
- op_valid  out  1  operand pair valid
- op_ready  in  1  execution unit accepts
- op_a, op_b  out  REGISTER_WIDTH  operands
- op_dst  out  ADDR_WIDTH; op_dst_en  out  1  forwarded destination info

## Operation
- Two registers: hold stage (request latched) and output stage (operands latched). FSM on hold stage: EMPTY, CHECK, STALL.
- EMPTY: req_ready=1; on accept latch srcA/srcB/dst/dst_en -> CHECK.
- CHECK/STALL: rf_readSelectA/B = held srcA/srcB. Hazard = scoreboard[srcA] or scoreboard[srcB] pending and not cleared this cycle, or (dst_en and scoreboard[dst] pending and not cleared this cycle).
- Capture: no hazard and output stage free (!op_valid or op_ready). Operand = wb value if matching wb_en this cycle (wb B takes priority over A on equal address), else rf_readResult. On capture, set scoreboard[dst] if dst_en; hold -> EMPTY, or CHECK if a new request is accepted in the same cycle.
- No capture -> STALL; retry every cycle.
- req_ready = hold EMPTY, or capture occurs this cycle (back-to-back throughput of 1/cycle).
- Scoreboard: 2**ADDR_WIDTH bits, cleared by wb_enA/wb_enB at their addresses. Same-cycle set and clear on one index: set wins.
- Output stage holds op_* stable while op_valid && !op_ready.
- Reads while wb_en targets an unpending register still take the bypass value.

## Timing
- Reset: req_ready=0 during reset, 1 from the first edge after release. op_valid=0; op_a/op_b/op_dst=0; op_dst_en=0; scoreboard all 0; FSM EMPTY; read selects 0.
- Latency: request accepted at edge N, selects driven in cycle N..N+1, op_valid high after edge N+1 (2 cycles) with no hazard.
- Stall: op_valid rises one cycle after the cycle in which the clearing writeback appears (bypassed value used).
- Reset asserted mid-operation: held request and output are discarded immediately (async); scoreboard is cleared.

## Structure
- Shared package/header (global.v): REGISTER_WIDTH, ADDR_WIDTH defaults, FSM state encodings.
- One sub-module: exp_scoreboard (bit vector with set port, two clear ports, and two-port pending lookup with clear-masking).

## Test plan
- Reset release, rf holds r1=0x0AA, r2=0x0EE; request srcA=1, srcB=2, dst=3 -> op_valid 2 cycles after accept, op_a=0x0AA, op_b=0x0EE, scoreboard[3]=1.
- RAW: next request srcA=3 -> stalls; wb_enA=1, addr=3, value=0x0BB after 4 cycles -> op_a=0x0BB (bypass), op_valid the cycle after.
- Simultaneous wb A and B to r5 (0x011 / 0x022) while a request reads r5 -> operand=0x022.
- Back-pressure: op_ready=0 for 3 cycles with 3 independent requests queued -> op_* stable, req_ready=0 after hold fills, no request lost, order preserved.
- WAW: dst=4 pending, new request dst=4 -> stalls until wb to r4; set and clear on r4 in the same cycle -> scoreboard[4] stays 1.
- Assert reset during STALL -> op_valid=0, scoreboard cleared, after release the next request completes with 2-cycle latency.

Source files
------------

// File: rtl/exp_operand_fetch_pkg.sv
// Shared defaults and hold-stage state encodings for the exponent operand-fetch stage.
package exp_operand_fetch_pkg;

  localparam int unsigned REGISTER_WIDTH_DEF = 9;
  localparam int unsigned ADDR_WIDTH_DEF     = 3;

  localparam logic [1:0] HOLD_EMPTY = 2'd0;
  localparam logic [1:0] HOLD_CHECK = 2'd1;
  localparam logic [1:0] HOLD_STALL = 2'd2;

  // CHECK and STALL both mean a request is parked and retrying.
  function automatic logic hold_occupied(input logic [1:0] state);
    return state != HOLD_EMPTY;
  endfunction

endpackage

// File: rtl/exp_scoreboard.sv
// In-flight destination tracker: one pending bit per register, set on issue,
// cleared by either writeback port; lookups see this cycle's clears.
module exp_scoreboard #(
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_en_i,
  input  logic [ADDR_WIDTH-1:0] set_addr_i,
  input  logic                  clr_a_en_i,
  input  logic [ADDR_WIDTH-1:0] clr_a_addr_i,
  input  logic                  clr_b_en_i,
  input  logic [ADDR_WIDTH-1:0] clr_b_addr_i,
  input  logic [ADDR_WIDTH-1:0] look_a_addr_i,
  input  logic [ADDR_WIDTH-1:0] look_b_addr_i,
  input  logic [ADDR_WIDTH-1:0] look_dst_addr_i,
  output logic                  pend_a_c,
  output logic                  pend_b_c,
  output logic                  pend_dst_c
);

  localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] pending_eff;

  // Clears mask the lookups immediately; a same-cycle set overrides a clear.
  always_comb begin
    clr_mask = '0;
    if (clr_a_en_i) clr_mask[clr_a_addr_i] = 1'b1;
    if (clr_b_en_i) clr_mask[clr_b_addr_i] = 1'b1;
    pending_eff = pending_q & ~clr_mask;
    pending_d   = pending_eff;
    if (set_en_i) pending_d[set_addr_i] = 1'b1;
  end

  assign pend_a_c   = pending_eff[look_a_addr_i];
  assign pend_b_c   = pending_eff[look_b_addr_i];
  assign pend_dst_c = pending_eff[look_dst_addr_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/exp_operand_fetch.sv
// Operand-fetch stage: parks one request, checks RAW/WAW against the scoreboard,
// bypasses same-cycle writebacks and registers the operand pair for execution.
module exp_operand_fetch
  import exp_operand_fetch_pkg::*;
#(
  parameter int unsigned REGISTER_WIDTH = REGISTER_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_WIDTH-1:0]     req_srcA,
  input  logic [ADDR_WIDTH-1:0]     req_srcB,
  input  logic [ADDR_WIDTH-1:0]     req_dst,
  input  logic                      req_dst_en,
  output logic [ADDR_WIDTH-1:0]     rf_readSelectA,
  output logic [ADDR_WIDTH-1:0]     rf_readSelectB,
  input  logic [REGISTER_WIDTH-1:0] rf_readResultA,
  input  logic [REGISTER_WIDTH-1:0] rf_readResultB,
  input  logic                      wb_enA,
  input  logic                      wb_enB,
  input  logic [ADDR_WIDTH-1:0]     wb_addrA,
  input  logic [ADDR_WIDTH-1:0]     wb_addrB,
  input  logic [REGISTER_WIDTH-1:0] wb_valueA,
  input  logic [REGISTER_WIDTH-1:0] wb_valueB,
  output logic                      op_valid,
  input  logic                      op_ready,
  output logic [REGISTER_WIDTH-1:0] op_a,
  output logic [REGISTER_WIDTH-1:0] op_b,
  output logic [ADDR_WIDTH-1:0]     op_dst,
  output logic                      op_dst_en
);

  logic [1:0]                hold_state_q, hold_state_d;
  logic [ADDR_WIDTH-1:0]     hold_src_a_q, hold_src_a_d;
  logic [ADDR_WIDTH-1:0]     hold_src_b_q, hold_src_b_d;
  logic [ADDR_WIDTH-1:0]     hold_dst_q,   hold_dst_d;
  logic                      hold_dst_en_q, hold_dst_en_d;
  logic                      live_q;

  logic                      op_valid_q,  op_valid_d;
  logic [REGISTER_WIDTH-1:0] op_a_q,      op_a_d;
  logic [REGISTER_WIDTH-1:0] op_b_q,      op_b_d;
  logic [ADDR_WIDTH-1:0]     op_dst_q,    op_dst_d;
  logic                      op_dst_en_q, op_dst_en_d;

  logic                      hold_busy;
  logic                      pend_a, pend_b, pend_dst;
  logic                      hazard;
  logic                      out_free;
  logic                      capture;
  logic                      accept;
  logic [REGISTER_WIDTH-1:0] byp_a, byp_b;

  exp_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk             (clk),
    .rst_n           (reset),
    .set_en_i        (capture && hold_dst_en_q),
    .set_addr_i      (hold_dst_q),
    .clr_a_en_i      (wb_enA),
    .clr_a_addr_i    (wb_addrA),
    .clr_b_en_i      (wb_enB),
    .clr_b_addr_i    (wb_addrB),
    .look_a_addr_i   (hold_src_a_q),
    .look_b_addr_i   (hold_src_b_q),
    .look_dst_addr_i (hold_dst_q),
    .pend_a_c        (pend_a),
    .pend_b_c        (pend_b),
    .pend_dst_c      (pend_dst)
  );

  assign hold_busy = hold_occupied(hold_state_q);
  assign hazard    = pend_a || pend_b || (hold_dst_en_q && pend_dst);
  assign out_free  = !op_valid_q || op_ready;
  assign capture   = hold_busy && !hazard && out_free;
  // live_q keeps the request port closed until the first edge after reset release.
  assign req_ready = live_q && (!hold_busy || capture);
  assign accept    = req_valid && req_ready;

  assign rf_readSelectA = hold_src_a_q;
  assign rf_readSelectB = hold_src_b_q;

  // Writeback bypass; port B wins when both ports hit the same register.
  always_comb begin
    byp_a = rf_readResultA;
    byp_b = rf_readResultB;
    if (wb_enA && (wb_addrA == hold_src_a_q)) byp_a = wb_valueA;
    if (wb_enB && (wb_addrB == hold_src_a_q)) byp_a = wb_valueB;
    if (wb_enA && (wb_addrA == hold_src_b_q)) byp_b = wb_valueA;
    if (wb_enB && (wb_addrB == hold_src_b_q)) byp_b = wb_valueB;
  end

  // Hold-stage next state: a new accept always refills, otherwise drain or stall.
  always_comb begin
    hold_state_d  = hold_state_q;
    hold_src_a_d  = hold_src_a_q;
    hold_src_b_d  = hold_src_b_q;
    hold_dst_d    = hold_dst_q;
    hold_dst_en_d = hold_dst_en_q;
    if (accept) begin
      hold_state_d  = HOLD_CHECK;
      hold_src_a_d  = req_srcA;
      hold_src_b_d  = req_srcB;
      hold_dst_d    = req_dst;
      hold_dst_en_d = req_dst_en;
    end else if (capture) begin
      hold_state_d  = HOLD_EMPTY;
    end else if (hold_busy) begin
      hold_state_d  = HOLD_STALL;
    end
  end

  // Output stage loads on capture and otherwise holds until the consumer takes it.
  always_comb begin
    op_valid_d  = op_valid_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_dst_d    = op_dst_q;
    op_dst_en_d = op_dst_en_q;
    if (capture) begin
      op_valid_d  = 1'b1;
      op_a_d      = byp_a;
      op_b_d      = byp_b;
      op_dst_d    = hold_dst_q;
      op_dst_en_d = hold_dst_en_q;
    end else if (op_ready) begin
      op_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_state_q <= HOLD_EMPTY;
    end else begin
      hold_state_q <= hold_state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_src_a_q  <= '0;
      hold_src_b_q  <= '0;
      hold_dst_q    <= '0;
      hold_dst_en_q <= 1'b0;
      live_q        <= 1'b0;
      op_valid_q    <= 1'b0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_dst_q      <= '0;
      op_dst_en_q   <= 1'b0;
    end else begin
      hold_src_a_q  <= hold_src_a_d;
      hold_src_b_q  <= hold_src_b_d;
      hold_dst_q    <= hold_dst_d;
      hold_dst_en_q <= hold_dst_en_d;
      live_q        <= 1'b1;
      op_valid_q    <= op_valid_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      op_dst_q      <= op_dst_d;
      op_dst_en_q   <= op_dst_en_d;
    end
  end

  assign op_valid  = op_valid_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_dst    = op_dst_q;
  assign op_dst_en = op_dst_en_q;

endmodule

// File: tb/tb_exp_operand_fetch.sv
// Directed bench for exp_operand_fetch: a register-file model feeds the DUT and a
// transaction-level checker compares every delivered operand pair against program order.
module tb_exp_operand_fetch;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready;
  logic [2:0] req_srcA, req_srcB, req_dst;
  logic       req_dst_en;
  logic [2:0] rf_readSelectA, rf_readSelectB;
  logic [8:0] rf_readResultA, rf_readResultB;
  logic       wb_enA, wb_enB;
  logic [2:0] wb_addrA, wb_addrB;
  logic [8:0] wb_valueA, wb_valueB;
  logic       op_valid, op_ready;
  logic [8:0] op_a, op_b;
  logic [2:0] op_dst;
  logic       op_dst_en;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exp_operand_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_srcA       (req_srcA),
    .req_srcB       (req_srcB),
    .req_dst        (req_dst),
    .req_dst_en     (req_dst_en),
    .rf_readSelectA (rf_readSelectA),
    .rf_readSelectB (rf_readSelectB),
    .rf_readResultA (rf_readResultA),
    .rf_readResultB (rf_readResultB),
    .wb_enA         (wb_enA),
    .wb_enB         (wb_enB),
    .wb_addrA       (wb_addrA),
    .wb_addrB       (wb_addrB),
    .wb_valueA      (wb_valueA),
    .wb_valueB      (wb_valueB),
    .op_valid       (op_valid),
    .op_ready       (op_ready),
    .op_a           (op_a),
    .op_b           (op_b),
    .op_dst         (op_dst),
    .op_dst_en      (op_dst_en)
  );

  // Register file environment: combinational read, write at the edge, port B wins.
  logic [8:0] rf_mem [8] = '{9'h000, 9'h0AA, 9'h0EE, 9'h033, 9'h044, 9'h055, 9'h066, 9'h077};
  assign rf_readResultA = rf_mem[rf_readSelectA];
  assign rf_readResultB = rf_mem[rf_readSelectB];
  always @(posedge clk) begin
    if (wb_enA) rf_mem[wb_addrA] <= wb_valueA;
    if (wb_enB) rf_mem[wb_addrB] <= wb_valueB;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ops leave in acceptance order; each carries the latest architectural
  // value of its sources (writebacks up to and including the capture cycle).
  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] d;
    logic       en;
  } req_t;
  req_t       exp_q[$];
  req_t       front, pushed;
  logic [8:0] arch [8] = '{9'h000, 9'h0AA, 9'h0EE, 9'h033, 9'h044, 9'h055, 9'h066, 9'h077};
  logic       prev_valid = 1'b0;
  logic       prev_hs    = 1'b0;
  logic [21:0] prev_pkt  = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_q.delete();
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
        chk("reset_op_valid", int'(op_valid), 0);
      end else begin
        if (prev_valid && !prev_hs) begin
          chk("op_stable", int'({op_a, op_b, op_dst, op_dst_en}), int'(prev_pkt));
        end else if (op_valid) begin
          if (exp_q.size() == 0) begin
            chk("op_unexpected", 1, 0);
          end else begin
            front = exp_q[0];
            chk("op_dst_order", int'(op_dst), int'(front.d));
            chk("op_dst_en_order", int'(op_dst_en), int'(front.en));
            chk("op_a_value", int'(op_a), int'(arch[front.a]));
            chk("op_b_value", int'(op_b), int'(arch[front.b]));
          end
        end
        if (op_valid && op_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (req_valid && req_ready) begin
          pushed.a  = req_srcA;
          pushed.b  = req_srcB;
          pushed.d  = req_dst;
          pushed.en = req_dst_en;
          exp_q.push_back(pushed);
        end
        prev_valid = op_valid;
        prev_hs    = op_valid && op_ready;
        prev_pkt   = {op_a, op_b, op_dst, op_dst_en};
      end
      if (wb_enA) arch[wb_addrA] = wb_valueA;
      if (wb_enB) arch[wb_addrB] = wb_valueB;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Present a request and hold it until accepted; ends just after the accepting edge.
  task automatic send(input logic [2:0] a, input logic [2:0] b, input logic [2:0] d,
                      input logic en);
    bit ok;
    ok         = 1'b0;
    req_valid  = 1'b1;
    req_srcA   = a;
    req_srcB   = b;
    req_dst    = d;
    req_dst_en = en;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 0, 1);
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_srcA = '0; req_srcB = '0; req_dst = '0;
    req_dst_en = 1'b0; op_ready = 1'b1;
    wb_enA = 1'b0; wb_enB = 1'b0; wb_addrA = '0; wb_addrB = '0;
    wb_valueA = '0; wb_valueB = '0;

    at_neg();
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_op_valid", int'(op_valid), 0);
    chk("rst_op_ab", int'({op_a, op_b}), 0);
    chk("rst_op_dst", int'({op_dst, op_dst_en}), 0);
    chk("rst_selects", int'({rf_readSelectA, rf_readSelectB}), 0);
    step();
    reset = 1'b1;
    at_neg();
    chk("ready_before_first_edge", int'(req_ready), 0);
    step();
    at_neg();
    chk("ready_after_first_edge", int'(req_ready), 1);
    step();

    // Basic issue, two-cycle latency.
    send(3'd1, 3'd2, 3'd3, 1'b1);
    at_neg();
    chk("lat_not_yet", int'(op_valid), 0);
    chk("sel_a", int'(rf_readSelectA), 1);
    chk("sel_b", int'(rf_readSelectB), 2);
    step();
    at_neg();
    chk("lat_valid", int'(op_valid), 1);
    chk("basic_a", int'(op_a), 'h0AA);
    chk("basic_b", int'(op_b), 'h0EE);
    chk("basic_dst", int'({op_dst, op_dst_en}), {3'd3, 1'b1});
    step();

    // RAW on r3, cleared by writeback A after four stalled cycles.
    send(3'd3, 3'd1, 3'd6, 1'b1);
    for (int i = 0; i < 4; i++) begin
      at_neg();
      chk("raw_stall_valid", int'(op_valid), 0);
      chk("raw_stall_ready", int'(req_ready), 0);
      step();
    end
    wb_enA = 1'b1; wb_addrA = 3'd3; wb_valueA = 9'h0BB;
    at_neg();
    chk("raw_clear_ready", int'(req_ready), 1);
    step();
    wb_enA = 1'b0;
    at_neg();
    chk("raw_valid", int'(op_valid), 1);
    chk("raw_bypass_a", int'(op_a), 'h0BB);
    chk("raw_b", int'(op_b), 'h0AA);
    step();

    // Retire r6, then dual writeback to r5 during the read: port B value wins.
    wb_enA = 1'b1; wb_addrA = 3'd6; wb_valueA = 9'h166;
    step();
    wb_enA = 1'b0;
    send(3'd5, 3'd5, 3'd0, 1'b0);
    wb_enA = 1'b1; wb_addrA = 3'd5; wb_valueA = 9'h011;
    wb_enB = 1'b1; wb_addrB = 3'd5; wb_valueB = 9'h022;
    at_neg();
    chk("dual_wb_ready", int'(req_ready), 1);
    step();
    wb_enA = 1'b0; wb_enB = 1'b0;
    at_neg();
    chk("dual_wb_a", int'(op_a), 'h022);
    chk("dual_wb_b", int'(op_b), 'h022);
    step();

    // Back-pressure with three independent requests.
    op_ready = 1'b0;
    send(3'd1, 3'd2, 3'd0, 1'b0);
    send(3'd2, 3'd4, 3'd7, 1'b0);
    req_valid = 1'b1; req_srcA = 3'd4; req_srcB = 3'd7; req_dst = 3'd1; req_dst_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("bp_ready_low", int'(req_ready), 0);
      chk("bp_valid", int'(op_valid), 1);
      chk("bp_hold_a", int'(op_a), 'h0AA);
      step();
    end
    op_ready = 1'b1;
    at_neg();
    chk("bp_release_ready", int'(req_ready), 1);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // WAW on r4, then set-and-clear on r4 in one cycle keeps it pending.
    send(3'd0, 3'd0, 3'd4, 1'b1);
    send(3'd1, 3'd1, 3'd4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("waw_stall", int'(req_ready), 0);
      step();
    end
    wb_enA = 1'b1; wb_addrA = 3'd4; wb_valueA = 9'h144;
    req_valid = 1'b1; req_srcA = 3'd4; req_srcB = 3'd0; req_dst = 3'd2; req_dst_en = 1'b0;
    at_neg();
    chk("waw_clear_ready", int'(req_ready), 1);
    step();
    wb_enA = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      at_neg();
      chk("set_wins_stall", int'(req_ready), 0);
      step();
    end
    wb_enB = 1'b1; wb_addrB = 3'd4; wb_valueB = 9'h155;
    at_neg();
    chk("set_wins_clear", int'(req_ready), 1);
    step();
    wb_enB = 1'b0;
    at_neg();
    chk("set_wins_bypass", int'(op_a), 'h155);
    step();

    // Reset while stalled on r5, then a clean two-cycle issue.
    send(3'd0, 3'd0, 3'd5, 1'b1);
    send(3'd5, 3'd0, 3'd0, 1'b0);
    at_neg();
    chk("pre_reset_stall", int'(req_ready), 0);
    step();
    reset = 1'b0;
    at_neg();
    chk("mid_reset_valid", int'(op_valid), 0);
    chk("mid_reset_ready", int'(req_ready), 0);
    step();
    reset = 1'b1;
    step();
    send(3'd5, 3'd3, 3'd2, 1'b1);
    at_neg();
    chk("post_reset_not_yet", int'(op_valid), 0);
    step();
    at_neg();
    chk("post_reset_valid", int'(op_valid), 1);
    chk("post_reset_a", int'(op_a), 'h022);
    chk("post_reset_b", int'(op_b), 'h0BB);
    step();
    for (int i = 0; i < 3; i++) step();
    at_neg();
    chk("all_ops_delivered", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
